// File: rtl/img_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : img_phase_sequencer
// Description : Sequences the image datapath through GRAY, COMPRESS and
//               ENCODE passes over a square frame. Generates the pixel
//               address stream, the capture and write strobes, the
//               block-boundary markers and sticky per-phase done flags.
//               Optional feature macro: PHASE_SEQ_ABORT_EN (adds abort_i).
// Revision    : 1.0 - initial release
// ============================================================================
module img_phase_sequencer #(
    parameter int IMG_LOG2 = 6,
    parameter int BLK_LOG2 = 2,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                dp_ready_i,
`ifdef PHASE_SEQ_ABORT_EN
    input  logic                abort_i,
`endif
    output logic [IMG_LOG2-1:0] row_o,
    output logic [IMG_LOG2-1:0] col_o,
    output logic                pix_ce_o,
    output logic                out_we_o,
    output logic [1:0]          phase_o,
    output logic                blk_first_o,
    output logic                blk_last_o,
    output logic                busy_o,
    output logic                gray_done_o,
    output logic                compress_done_o,
    output logic                encode_done_o
);

    localparam int IDX_W = 2 * IMG_LOG2;
    localparam int BR_W  = IMG_LOG2 - BLK_LOG2;
    localparam int BP_W  = 2 * BLK_LOG2;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;
    localparam logic [BP_W-1:0]  BPOS_LAST = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GRAY = 3'd1,
        ST_COMP = 3'd2,
        ST_ENC  = 3'd3,
        ST_DONE = 3'd4
    } top_e;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_CAP  = 2'd1,
        S_WR   = 2'd2
    } pix_e;

    top_e               top_q, top_d;
    pix_e               pix_q, pix_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [2:0]         done_q, done_d;

    logic [IMG_LOG2-1:0] row_q, row_d;
    logic [IMG_LOG2-1:0] col_q, col_d;
    logic                pix_ce_q, pix_ce_d;
    logic [1:0]          phase_q, phase_d;
    logic                blk_first_q, blk_first_d;
    logic                blk_last_q, blk_last_d;
    logic                busy_q, busy_d;

    logic                abort_req;

`ifdef PHASE_SEQ_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    // Next-state logic for the phase FSM, the pixel sub-FSM, the index and flags.
    always_comb begin
        top_d  = top_q;
        pix_d  = pix_q;
        idx_d  = idx_q;
        lat_d  = lat_q;
        done_d = done_q;

        case (top_q)
            ST_IDLE, ST_DONE: begin
                // abort has priority over start so an abort+start pair stays idle
                if (start_i && !abort_req) begin
                    top_d  = ST_GRAY;
                    pix_d  = S_ADDR;
                    idx_d  = '0;
                    lat_d  = '0;
                    done_d = '0;
                end
            end
            ST_GRAY, ST_COMP, ST_ENC: begin
                if (abort_req) begin
                    top_d  = ST_IDLE;
                    pix_d  = S_ADDR;
                    idx_d  = '0;
                    lat_d  = '0;
                    done_d = '0;
                end else begin
                    case (pix_q)
                        S_ADDR: begin
                            if (lat_q == LAT_LAST) begin
                                pix_d = S_CAP;
                                lat_d = '0;
                            end else begin
                                lat_d = lat_q + 1'b1;
                            end
                        end
                        S_CAP: begin
                            pix_d = S_WR;
                        end
                        S_WR: begin
                            if (dp_ready_i) begin
                                pix_d = S_ADDR;
                                lat_d = '0;
                                if (idx_q == IDX_LAST) begin
                                    // Last pixel of the pass: hand straight over to the next pass
                                    idx_d = '0;
                                    case (top_q)
                                        ST_GRAY: begin
                                            done_d[0] = 1'b1;
                                            top_d     = ST_COMP;
                                        end
                                        ST_COMP: begin
                                            done_d[1] = 1'b1;
                                            top_d     = ST_ENC;
                                        end
                                        default: begin
                                            done_d[2] = 1'b1;
                                            top_d     = ST_DONE;
                                        end
                                    endcase
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                end
                            end
                        end
                        default: begin
                            pix_d = S_ADDR;
                        end
                    endcase
                end
            end
            default: begin
                top_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every strobe/address leaves a flop.
    always_comb begin
        row_d       = '0;
        col_d       = '0;
        pix_ce_d    = 1'b0;
        phase_d     = 2'd0;
        blk_first_d = 1'b0;
        blk_last_d  = 1'b0;
        busy_d      = 1'b0;

        case (top_d)
            ST_GRAY: begin
                // Raster order: upper half of idx is the row, lower half the column
                row_d    = idx_d[IDX_W-1 -: IMG_LOG2];
                col_d    = idx_d[IMG_LOG2-1:0];
                pix_ce_d = (pix_d == S_CAP);
                phase_d  = 2'd1;
                busy_d   = 1'b1;
            end
            ST_COMP, ST_ENC: begin
                // Block-major order: {block row, block col, row in block, col in block}
                row_d       = {idx_d[IDX_W-1 -: BR_W], idx_d[BP_W-1 -: BLK_LOG2]};
                col_d       = {idx_d[IMG_LOG2+BLK_LOG2-1 -: BR_W], idx_d[BLK_LOG2-1:0]};
                pix_ce_d    = (pix_d == S_CAP);
                phase_d     = (top_d == ST_COMP) ? 2'd2 : 2'd3;
                blk_first_d = (idx_d[BP_W-1:0] == '0);
                blk_last_d  = (idx_d[BP_W-1:0] == BPOS_LAST);
                busy_d      = 1'b1;
            end
            default: begin
                row_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset to the idle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q       <= ST_IDLE;
            pix_q       <= S_ADDR;
            idx_q       <= '0;
            lat_q       <= '0;
            done_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pix_ce_q    <= 1'b0;
            phase_q     <= 2'd0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            top_q       <= top_d;
            pix_q       <= pix_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            done_q      <= done_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pix_ce_q    <= pix_ce_d;
            phase_q     <= phase_d;
            blk_first_q <= blk_first_d;
            blk_last_q  <= blk_last_d;
            busy_q      <= busy_d;
        end
    end

    // The write strobe is the only output that follows an input combinationally.
    assign out_we_o        = busy_q && (pix_q == S_WR) && dp_ready_i;
    assign row_o           = row_q;
    assign col_o           = col_q;
    assign pix_ce_o        = pix_ce_q;
    assign phase_o         = phase_q;
    assign blk_first_o     = blk_first_q;
    assign blk_last_o      = blk_last_q;
    assign busy_o          = busy_q;
    assign gray_done_o     = done_q[0];
    assign compress_done_o = done_q[1];
    assign encode_done_o   = done_q[2];

endmodule
`default_nettype wire
